// File: rtl/rca_arbiter.sv
// ---------------------------------------------------------------------------
// rca_arbiter
//   Round-robin arbiter and sequencer in front of one shared external
//   ripple-carry add/sub unit. One operation is in flight at a time:
//   IDLE picks a winner and registers its operands onto the adder inputs,
//   SETTLE holds them for SETTLE_CYCLES cycles (the adder is a multicycle
//   path), then RESP presents the registered result until it is consumed.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   req_valid        per-requester request
//   req_ready        per-requester accept (one-hot or zero)
//   req_add_sub_b    per-requester op, 1 = add, 0 = subtract (a - b)
//   req_a, req_b     flattened operands, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   rsp_valid        response valid
//   rsp_ready        response consumer ready
//   rsp_id           requester index of the response
//   rsp_result       registered adder result
//   rsp_ovf          registered adder signed-overflow flag
//   busy             high whenever not IDLE
//   adder_add_sub_b  registered op to the external adder
//   adder_in1/2      registered operands to the external adder
//   adder_out        external adder result (combinational)
//   adder_ovf        external adder signed overflow
// ---------------------------------------------------------------------------
module rca_arbiter #(
   parameter int BUS_WIDTH     = 32,
   parameter int NUM_REQ       = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0]           req_add_sub_b,
   input  logic [NUM_REQ*BUS_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*BUS_WIDTH-1:0] req_b,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [BUS_WIDTH-1:0]         rsp_result,
   output logic                         rsp_ovf,
   output logic                         busy,
   output logic                         adder_add_sub_b,
   output logic [BUS_WIDTH-1:0]         adder_in1,
   output logic [BUS_WIDTH-1:0]         adder_in2,
   input  logic [BUS_WIDTH-1:0]         adder_out,
   input  logic                         adder_ovf
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [ID_W-1:0]      last_grant_q;
   logic [CNT_W-1:0]     cnt_q;

   logic                 win_found;
   logic [ID_W-1:0]      win_idx;
   logic [ID_W-1:0]      scan_idx;
   logic                 accept;

   logic [BUS_WIDTH-1:0] a_arr [NUM_REQ];
   logic [BUS_WIDTH-1:0] b_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*BUS_WIDTH +: BUS_WIDTH];
      assign b_arr[i] = req_b[i*BUS_WIDTH +: BUS_WIDTH];
   end

   // Rotating priority search: start just after the last winner so the
   // requester served most recently has the lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
         if (!win_found && req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign accept = |(req_valid & req_ready);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)        state_d = SETTLE;
         SETTLE:  if (cnt_q == '0)   state_d = RESP;
         RESP:    if (rsp_ready)     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Output logic; req_ready is forced low during reset so nothing is
   // accepted on the reset edge.
   always_comb begin
      req_ready = '0;
      if ((state_q == IDLE) && !rst && win_found) begin
         req_ready[win_idx] = 1'b1;
      end
      busy      = (state_q != IDLE);
      rsp_valid = (state_q == RESP);
   end

   // Operand / result registers, grant pointer and settle counter.
   // Adder inputs are deliberately left untouched outside the accept
   // cycle so they stay quiet between operations.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q    <= ID_W'(NUM_REQ - 1);
         cnt_q           <= '0;
         adder_add_sub_b <= 1'b0;
         adder_in1       <= '0;
         adder_in2       <= '0;
         rsp_id          <= '0;
         rsp_result      <= '0;
         rsp_ovf         <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  adder_add_sub_b <= req_add_sub_b[win_idx];
                  adder_in1       <= a_arr[win_idx];
                  adder_in2       <= b_arr[win_idx];
                  rsp_id          <= win_idx;
                  last_grant_q    <= win_idx;
                  cnt_q           <= CNT_W'(SETTLE_CYCLES - 1);
               end
            end
            SETTLE: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  rsp_result <= adder_out;
                  rsp_ovf    <= adder_ovf;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rca_arbiter
//   Testbench for rca_arbiter. Provides a behavioural add/sub unit on the
//   adder_* ports and a transaction-level reference model (round-robin pick,
//   latency rule, signed arithmetic on wide integers).
// ---------------------------------------------------------------------------
module tb_rca_arbiter;

   localparam int W = 32;
   localparam int N = 4;
   localparam int S = 2;
   localparam int IW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_add_sub_b;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [W-1:0]    rsp_result;
   logic            rsp_ovf;
   logic            busy;
   logic            adder_add_sub_b;
   logic [W-1:0]    adder_in1;
   logic [W-1:0]    adder_in2;
   logic [W-1:0]    adder_out;
   logic            adder_ovf;

   always #5 clk = ~clk;

   rca_arbiter #(.BUS_WIDTH(W), .NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_add_sub_b(req_add_sub_b), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .busy(busy),
      .adder_add_sub_b(adder_add_sub_b), .adder_in1(adder_in1),
      .adder_in2(adder_in2), .adder_out(adder_out), .adder_ovf(adder_ovf)
   );

   // External ripple-carry unit stand-in
   assign adder_out = adder_add_sub_b ? adder_in1 + adder_in2 : adder_in1 - adder_in2;
   assign adder_ovf = adder_add_sub_b
      ? ((adder_in1[W-1] == adder_in2[W-1]) && (adder_out[W-1] != adder_in1[W-1]))
      : ((adder_in1[W-1] != adder_in2[W-1]) && (adder_out[W-1] != adder_in1[W-1]));

   int nchk = 0;
   int nbad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int           cyc = 0;
   bit           pend = 0;
   int           hs = 0;
   int           last = N - 1;
   int           eid = 0;
   int           acc_id = -1;
   logic [W-1:0] eres;
   bit           eovf;
   logic [W-1:0] ma = '0, mb = '0;
   bit           mop = 0;
   bit           after_rst = 0;
   int           got_q[$];
   logic [W-1:0] got_res;
   bit           got_ovf;

   function automatic int pick(input logic [N-1:0] v, input int lg);
      for (int k = 1; k <= N; k++)
         if (v[(lg + k) % N]) return (lg + k) % N;
      return -1;
   endfunction

   task automatic ref_calc(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output bit ovf);
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = op ? sa + sb : sa - sb;
      ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      res = r[W-1:0];
   endtask

   // One clock cycle: check outputs against the model, advance the model,
   // then move past the next rising edge.
   task automatic step();
      int w;
      bit ev;
      logic [N-1:0] exp_rdy;
      #1;
      acc_id = -1;
      if (rst) begin
         chk("rdy_in_rst", req_ready, 0);
         pend = 0; last = N - 1; ma = '0; mb = '0; mop = 0; after_rst = 1;
      end else begin
         if (after_rst) begin
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_ovf", rsp_ovf, 0);
            after_rst = 0;
         end
         chk("adder_in1", adder_in1, ma);
         chk("adder_in2", adder_in2, mb);
         chk("adder_op", adder_add_sub_b, mop);
         chk("busy", busy, pend);
         if (!pend) begin
            w = pick(req_valid, last);
            exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
            chk("req_ready", req_ready, exp_rdy);
            chk("rsp_valid_idle", rsp_valid, 0);
            if (w >= 0) begin
               pend = 1; hs = cyc; eid = w; last = w; acc_id = w;
               mop = req_add_sub_b[w];
               ma  = req_a[w*W +: W];
               mb  = req_b[w*W +: W];
               ref_calc(mop, ma, mb, eres, eovf);
            end
         end else begin
            chk("req_ready_busy", req_ready, 0);
            ev = (cyc >= hs + S + 1);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
               chk("rsp_id", rsp_id, eid);
               chk("rsp_result", rsp_result, eres);
               chk("rsp_ovf", rsp_ovf, eovf);
               if (rsp_ready) begin
                  pend = 0;
                  got_q.push_back(eid);
                  got_res = rsp_result;
                  got_ovf = rsp_ovf;
               end
            end
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic set_req(input int i, input bit v, input bit op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i]     = v;
      req_add_sub_b[i] = op;
      req_a[i*W +: W]  = a;
      req_b[i*W +: W]  = b;
   endtask

   task automatic wait_hs(input string tag);
      int n = 0;
      while (!pend && n < 20) begin step(); n++; end
      if (!pend) chk(tag, 0, 1);
   endtask

   task automatic wait_rsp(input string tag, input int cnt);
      int n = 0;
      while (got_q.size() < cnt && n < 100) begin step(); n++; end
      if (got_q.size() < cnt) chk(tag, got_q.size(), cnt);
   endtask

   task automatic run_one(input string tag, input int i, input bit op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input bit eo);
      int n0 = got_q.size();
      set_req(i, 1, op, a, b);
      wait_hs({tag, "_hs_timeout"});
      req_valid[i] = 1'b0;
      wait_rsp({tag, "_rsp_timeout"}, n0 + 1);
      chk({tag, "_res"}, got_res, er);
      chk({tag, "_ovf"}, got_ovf, eo);
      chk({tag, "_id"}, got_q[got_q.size()-1], i);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   logic [W-1:0] edge_v [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};

   function automatic logic [W-1:0] rnd_op();
      if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      int n0;
      int exp_seq[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 2};
      rst = 1'b1; rsp_ready = 1'b1;
      req_valid = '0; req_add_sub_b = '0; req_a = '0; req_b = '0;
      @(posedge clk); #1;
      do_reset();

      // basic add, subtract, overflow cases
      run_one("t1_add", 1, 1, 32'd110, 32'd24, 32'd134, 0);
      run_one("t2_sub", 0, 0, 32'd110, 32'd24, 32'd86, 0);
      run_one("t2_neg", 2, 0, 32'd24, 32'd110, 32'hFFFF_FFAA, 0);
      run_one("t3_addovf", 3, 1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
      run_one("t3_subovf", 0, 0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1);

      // round-robin order
      do_reset();
      got_q.delete();
      for (int i = 0; i < N; i++) set_req(i, 1, i[0], W'(i * 7), W'(i + 3));
      wait_rsp("t4_rr_timeout", 6);
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      wait_rsp("t4_pair_timeout", 9);
      req_valid = '0;
      for (int i = 0; i < 9 && i < got_q.size(); i++) chk($sformatf("t4_seq%0d", i), got_q[i], exp_seq[i]);
      for (int i = 0; i < S + 4; i++) step();

      // back-pressure on the response channel
      n0 = got_q.size();
      rsp_ready = 1'b0;
      set_req(2, 1, 1, 32'd1000, 32'd234);
      wait_hs("t5_hs_timeout");
      set_req(2, 0, 1, 32'd1000, 32'd234);
      set_req(0, 1, 1, 32'd5, 32'd6);
      for (int i = 0; i < S + 1; i++) step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_hold_valid", rsp_valid, 1);
         chk("t5_hold_res", rsp_result, 32'd1234);
      end
      req_valid[0] = 1'b0;
      rsp_ready = 1'b1;
      wait_rsp("t5_rsp_timeout", n0 + 1);
      for (int i = 0; i < 5; i++) step();
      chk("t5_single", got_q.size(), n0 + 1);

      // reset in the middle of SETTLE
      n0 = got_q.size();
      set_req(1, 1, 1, 32'd9, 32'd9);
      wait_hs("t6_hs_timeout");
      req_valid = '0;
      step();
      rst = 1'b1; step(); rst = 1'b0;
      req_valid = '1;
      wait_hs("t6_hs2_timeout");
      chk("t6_first_grant", eid, 0);
      req_valid = '0;
      chk("t6_no_rsp", got_q.size(), n0);
      wait_rsp("t6_rsp_timeout", n0 + 1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (acc_id == i) begin
               if ($urandom_range(0, 2) == 0) set_req(i, 1, $urandom_range(0, 1), rnd_op(), rnd_op());
               else req_valid[i] = 1'b0;
            end else if (!req_valid[i]) begin
               if ($urandom_range(0, 9) < 3) set_req(i, 1, $urandom_range(0, 1), rnd_op(), rnd_op());
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule
